// File: rtl/ucie_rdi_pkg.sv
// UCIe RDI shared types: RDI state encodings and the
// internal physical-layer responder FSM states.
package ucie_rdi_pkg;

  typedef enum logic [3:0] {
    RDI_RESET     = 4'h0,
    RDI_ACTIVE    = 4'h1,
    RDI_L1        = 4'h4,
    RDI_LINKRESET = 4'h9,
    RDI_LINKERROR = 4'hA,
    RDI_RETRAIN   = 4'hB
  } rdi_state_e;

  typedef enum logic [2:0] {
    S_RESET,
    S_ACTIVE,
    S_STALL_REQ,
    S_STALL_REL,
    S_L1,
    S_RETRAIN,
    S_LINKRESET,
    S_LINKERROR
  } fsm_e;

  // Stall phases still report ACTIVE to the adapter.
  function automatic rdi_state_e sts_of(fsm_e s);
    rdi_state_e r;
    r = RDI_RESET;
    unique case (s)
      S_RESET:     r = RDI_RESET;
      S_ACTIVE:    r = RDI_ACTIVE;
      S_STALL_REQ: r = RDI_ACTIVE;
      S_STALL_REL: r = RDI_ACTIVE;
      S_L1:        r = RDI_L1;
      S_RETRAIN:   r = RDI_RETRAIN;
      S_LINKRESET: r = RDI_LINKRESET;
      S_LINKERROR: r = RDI_LINKERROR;
      default:     r = RDI_RESET;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ucie_rdi_stall_hs.sv
// Stall request/ack handshake tracker with the shared
// saturating timeout/hold counter.
module ucie_rdi_stall_hs #(
  parameter int STALL_TIMEOUT  = 1024,
  parameter int LINKRESET_HOLD = 16,
  parameter int CNT_W          = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic in_req,
  input  logic in_rel,
  input  logic in_hold,
  input  logic clr,
  input  logic lp_stallack,
  output logic ack,
  output logic done,
  output logic timeout,
  output logic hold_done
);

  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(STALL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(LINKRESET_HOLD - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (!(&cnt_q))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign ack       = in_req & lp_stallack;
  assign done      = in_rel & ~lp_stallack;
  assign timeout   = (in_req | in_rel) & (cnt_q == TO_LAST);
  assign hold_done = in_hold & (cnt_q == HOLD_LAST);

endmodule

// File: rtl/ucie_rdi_pl_state_ctrl.sv
// Physical-layer RDI state responder: follows adapter
// state requests, runs the stall handshake, gates tx.
module ucie_rdi_pl_state_ctrl #(
  parameter int STALL_TIMEOUT  = 1024,
  parameter int LINKRESET_HOLD = 16,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] lp_state_req,
  input  logic       lp_stallack,
  input  logic       lp_wake_req,
  input  logic       phy_link_up,
  input  logic       phy_retrain_req,
  input  logic       phy_error,
  output logic [3:0] pl_state_sts,
  output logic       pl_stallreq,
  output logic       pl_wake_ack,
  output logic       pl_clk_req,
  output logic       tx_ready,
  output logic       link_up,
  output logic       link_error
);

  import ucie_rdi_pkg::*;

  fsm_e state_q, state_d;
  fsm_e tgt_q, tgt_d;

  logic hs_ack, hs_done, hs_to, hs_hold_done;

  logic [3:0] sts_q, sts_d;
  logic       stallreq_q, stallreq_d;
  logic       tx_ready_q, tx_ready_d;
  logic       link_up_q, link_up_d;
  logic       link_error_q, link_error_d;
  logic       wake_ack_q, wake_ack_d;

  ucie_rdi_stall_hs #(
    .STALL_TIMEOUT  (STALL_TIMEOUT),
    .LINKRESET_HOLD (LINKRESET_HOLD),
    .CNT_W          (CNT_W)
  ) u_hs (
    .clk         (clk),
    .reset       (reset),
    .in_req      (state_q == S_STALL_REQ),
    .in_rel      (state_q == S_STALL_REL),
    .in_hold     (state_q == S_LINKRESET),
    .clr         (state_d != state_q),
    .lp_stallack (lp_stallack),
    .ack         (hs_ack),
    .done        (hs_done),
    .timeout     (hs_to),
    .hold_done   (hs_hold_done)
  );

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    if (phy_error && state_q != S_RESET &&
        state_q != S_LINKERROR) begin
      state_d = S_LINKERROR;
    end else begin
      unique case (state_q)
        S_RESET:
          if (phy_link_up && lp_state_req == RDI_ACTIVE)
            state_d = S_ACTIVE;
        S_ACTIVE:
          if (lp_state_req == RDI_LINKRESET) begin
            state_d = S_STALL_REQ;
            tgt_d   = S_LINKRESET;
          end else if (phy_retrain_req ||
                       lp_state_req == RDI_RETRAIN) begin
            state_d = S_STALL_REQ;
            tgt_d   = S_RETRAIN;
          end else if (lp_state_req == RDI_L1) begin
            state_d = S_STALL_REQ;
            tgt_d   = S_L1;
          end
        S_STALL_REQ:
          if (hs_ack)
            state_d = S_STALL_REL;
          else if (hs_to)
            state_d = S_LINKERROR;
        S_STALL_REL:
          if (hs_done)
            state_d = tgt_q;
          else if (hs_to)
            state_d = S_LINKERROR;
        S_L1:
          if (lp_state_req == RDI_ACTIVE)
            state_d = S_RETRAIN;
        S_RETRAIN:
          if (phy_link_up && !phy_retrain_req &&
              lp_state_req == RDI_ACTIVE)
            state_d = S_ACTIVE;
        S_LINKRESET:
          if (hs_hold_done)
            state_d = S_RESET;
        S_LINKERROR:
          if (lp_state_req == RDI_RESET && !phy_error)
            state_d = S_RESET;
        default:
          state_d = S_RESET;
      endcase
    end
  end

  // Outputs decode the next state so they land with it.
  always_comb begin
    sts_d        = sts_of(state_d);
    stallreq_d   = (state_d == S_STALL_REQ);
    tx_ready_d   = (state_d == S_ACTIVE);
    link_up_d    = (sts_of(state_d) == RDI_ACTIVE);
    link_error_d = (state_d == S_LINKERROR);
    wake_ack_d   = lp_wake_req;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_RESET;
      tgt_q        <= S_RESET;
      sts_q        <= 4'h0;
      stallreq_q   <= 1'b0;
      tx_ready_q   <= 1'b0;
      link_up_q    <= 1'b0;
      link_error_q <= 1'b0;
      wake_ack_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      tgt_q        <= tgt_d;
      sts_q        <= sts_d;
      stallreq_q   <= stallreq_d;
      tx_ready_q   <= tx_ready_d;
      link_up_q    <= link_up_d;
      link_error_q <= link_error_d;
      wake_ack_q   <= wake_ack_d;
    end
  end

  assign pl_state_sts = sts_q;
  assign pl_stallreq  = stallreq_q;
  assign tx_ready     = tx_ready_q;
  assign link_up      = link_up_q;
  assign link_error   = link_error_q;
  assign pl_wake_ack  = wake_ack_q;
  assign pl_clk_req   = wake_ack_q;

endmodule

// File: tb/tb_ucie_rdi_pl_state_ctrl.sv
// Directed bench for the RDI physical-layer responder,
// built with a short stall timeout of 8 cycles.
module tb_ucie_rdi_pl_state_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] lp_state_req;
  logic       lp_stallack;
  logic       lp_wake_req;
  logic       phy_link_up;
  logic       phy_retrain_req;
  logic       phy_error;
  logic [3:0] pl_state_sts;
  logic       pl_stallreq;
  logic       pl_wake_ack;
  logic       pl_clk_req;
  logic       tx_ready;
  logic       link_up;
  logic       link_error;

  int total = 0;
  int bad   = 0;
  int hi;

  ucie_rdi_pl_state_ctrl #(
    .STALL_TIMEOUT  (8),
    .LINKRESET_HOLD (16),
    .CNT_W          (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .lp_state_req    (lp_state_req),
    .lp_stallack     (lp_stallack),
    .lp_wake_req     (lp_wake_req),
    .phy_link_up     (phy_link_up),
    .phy_retrain_req (phy_retrain_req),
    .phy_error       (phy_error),
    .pl_state_sts    (pl_state_sts),
    .pl_stallreq     (pl_stallreq),
    .pl_wake_ack     (pl_wake_ack),
    .pl_clk_req      (pl_clk_req),
    .tx_ready        (tx_ready),
    .link_up         (link_up),
    .link_error      (link_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    reset           = 1'b1;
    lp_state_req    = 4'h0;
    lp_stallack     = 1'b0;
    lp_wake_req     = 1'b0;
    phy_link_up     = 1'b0;
    phy_retrain_req = 1'b0;
    phy_error       = 1'b0;
    tick();
    tick();
    chk("rst_sts", pl_state_sts, 4'h0);
    chk("rst_stallreq", pl_stallreq, 0);
    chk("rst_txrdy", tx_ready, 0);
    chk("rst_linkup", link_up, 0);
    chk("rst_linkerr", link_error, 0);
    chk("rst_wake", pl_wake_ack, 0);
    chk("rst_clkreq", pl_clk_req, 0);
    reset = 1'b0;

    lp_state_req = 4'h1;
    tick();
    chk("nolink_sts", pl_state_sts, 4'h0);
    phy_link_up = 1'b1;
    tick();
    chk("act_sts", pl_state_sts, 4'h1);
    chk("act_linkup", link_up, 1);
    chk("act_txrdy", tx_ready, 1);

    lp_state_req = 4'h3;
    tick();
    chk("unlisted_sts", pl_state_sts, 4'h1);
    chk("unlisted_stall", pl_stallreq, 0);

    // L1 entry: stallack answers after 5, drops after 2
    lp_state_req = 4'h4;
    hi = 0;
    tick();
    for (int i = 0; i < 6; i++) begin
      if (pl_stallreq === 1'b1) hi++;
      chk("l1_txrdy", tx_ready, 0);
      chk("l1_sts_req", pl_state_sts, 4'h1);
      if (i == 5) lp_stallack = 1'b1;
      tick();
    end
    chk("l1_stall_hi", hi, 6);
    chk("l1_stall_low", pl_stallreq, 0);
    chk("l1_sts_rel", pl_state_sts, 4'h1);
    tick();
    chk("l1_sts_rel2", pl_state_sts, 4'h1);
    lp_stallack = 1'b0;
    tick();
    chk("l1_sts", pl_state_sts, 4'h4);
    chk("l1_txrdy_end", tx_ready, 0);

    lp_state_req    = 4'h1;
    phy_retrain_req = 1'b1;
    tick();
    chk("wake_retrain", pl_state_sts, 4'hB);
    tick();
    chk("retrain_hold", pl_state_sts, 4'hB);
    phy_retrain_req = 1'b0;
    tick();
    chk("retrain_act", pl_state_sts, 4'h1);
    chk("retrain_txrdy", tx_ready, 1);

    lp_state_req = 4'hB;
    tick();
    chk("to_stallreq", pl_stallreq, 1);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("to_noerr", link_error, 0);
    end
    tick();
    chk("to_linkerr", link_error, 1);
    chk("to_sts", pl_state_sts, 4'hA);
    chk("to_stall_clr", pl_stallreq, 0);

    lp_state_req = 4'h0;
    phy_error    = 1'b1;
    tick();
    chk("err_hold", pl_state_sts, 4'hA);
    phy_error = 1'b0;
    tick();
    chk("err_exit", pl_state_sts, 4'h0);
    chk("err_exit_le", link_error, 0);

    lp_state_req = 4'h1;
    tick();
    chk("re_act", pl_state_sts, 4'h1);

    // retrain and linkreset together: linkreset wins
    phy_retrain_req = 1'b1;
    lp_state_req    = 4'h9;
    tick();
    chk("pri_stallreq", pl_stallreq, 1);
    phy_retrain_req = 1'b0;
    lp_stallack     = 1'b1;
    tick();
    chk("pri_rel", pl_stallreq, 0);
    lp_stallack  = 1'b0;
    lp_state_req = 4'h0;
    tick();
    chk("lr_sts", pl_state_sts, 4'h9);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("lr_hold", pl_state_sts, 4'h9);
    end
    tick();
    chk("lr_done", pl_state_sts, 4'h0);

    lp_state_req = 4'h1;
    tick();
    chk("act2", pl_state_sts, 4'h1);
    lp_state_req = 4'h4;
    tick();
    chk("err_stallreq", pl_stallreq, 1);
    tick();
    chk("err_stallreq2", pl_stallreq, 1);
    phy_error = 1'b1;
    tick();
    chk("err_mid_stall", pl_stallreq, 0);
    chk("err_mid_sts", pl_state_sts, 4'hA);
    chk("err_mid_le", link_error, 1);
    phy_error    = 1'b0;
    lp_state_req = 4'h0;
    tick();
    chk("err_mid_exit", pl_state_sts, 4'h0);

    lp_state_req = 4'h1;
    tick();
    chk("act3", pl_state_sts, 4'h1);
    phy_error    = 1'b1;
    lp_state_req = 4'h9;
    tick();
    chk("err_pri_sts", pl_state_sts, 4'hA);
    chk("err_pri_stall", pl_stallreq, 0);
    phy_error    = 1'b0;
    lp_state_req = 4'h0;
    tick();
    chk("err_pri_exit", pl_state_sts, 4'h0);

    lp_wake_req = 1'b1;
    chk("wake_lag", pl_wake_ack, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wake_ack", pl_wake_ack, 1);
      chk("wake_clk", pl_clk_req, 1);
    end
    lp_wake_req = 1'b0;
    tick();
    chk("wake_off", pl_wake_ack, 0);
    chk("wake_clk_off", pl_clk_req, 0);

    lp_state_req = 4'h1;
    tick();
    chk("act4", pl_state_sts, 4'h1);
    lp_state_req = 4'h4;
    lp_wake_req  = 1'b1;
    tick();
    chk("mid_stallreq", pl_stallreq, 1);
    chk("mid_wake", pl_wake_ack, 1);
    reset = 1'b1;
    tick();
    chk("mr_sts", pl_state_sts, 4'h0);
    chk("mr_stall", pl_stallreq, 0);
    chk("mr_wake", pl_wake_ack, 0);
    chk("mr_clk", pl_clk_req, 0);
    chk("mr_txrdy", tx_ready, 0);
    chk("mr_linkup", link_up, 0);
    chk("mr_linkerr", link_error, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ucie_rdi_pl_state_ctrl.md
Name: ucie_rdi_pl_state_ctrl

Overview:
Physical-layer-side RDI state responder; drives the controller-side RDI control signals. Accepts adapter state requests (lp_state_req), runs the stallreq/stallack handshake before leaving Active, reports pl_state_sts, and gates tx_ready. Sits between link training (phy_* inputs) and the RDI boundary, paired with the adapter-side requester.

Parameters:
STALL_TIMEOUT, 1024, cycles to wait for lp_stallack assert or deassert before LinkError
LINKRESET_HOLD, 16, cycles spent in LinkReset before returning to Reset
CNT_W, 16, width of the shared timeout/hold counter; must satisfy 2^CNT_W > max(STALL_TIMEOUT, LINKRESET_HOLD)

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-high
lp_state_req  in  4  adapter state request
lp_stallack  in  1  adapter stall acknowledge
lp_wake_req  in  1  adapter wake request
phy_link_up  in  1  training complete, lanes usable
phy_retrain_req  in  1  PHY requests retrain (level)
phy_error  in  1  fatal PHY error (level)
pl_state_sts  out  4  current RDI state
pl_stallreq  out  1  stall request to adapter
pl_wake_ack  out  1  wake acknowledge
pl_clk_req  out  1  clock request, mirrors pl_wake_ack
tx_ready  out  1  transmit ready
link_up  out  1  high only in ACTIVE
link_error  out  1  high only in LINKERROR

Behaviour:
- Encodings (pkg): RESET 4'h0, ACTIVE 4'h1, L1 4'h4, LINKRESET 4'h9, LINKERROR 4'hA, RETRAIN 4'hB. Unlisted lp_state_req values are ignored (no transition).
- Internal FSM: S_RESET, S_ACTIVE, S_STALL_REQ, S_STALL_REL, S_L1, S_RETRAIN, S_LINKRESET, S_LINKERROR. Target register latches the exit reason on entering S_STALL_REQ.
- Reset (synchronous): S_RESET; all outputs 0; pl_state_sts=RESET; counter=0.
- All outputs registered; every transition is visible on outputs 1 cycle after the triggering input sample.
- S_RESET -> S_ACTIVE when phy_link_up && lp_state_req==ACTIVE.
- S_ACTIVE: tx_ready=1, link_up=1. Exit priority when several are true: phy_error (LINKERROR, no stall) > lp_state_req==LINKRESET > phy_retrain_req or lp_state_req==RETRAIN > lp_state_req==L1. Every non-error exit goes to S_STALL_REQ with the target latched.
- S_STALL_REQ: pl_stallreq=1, tx_ready=0, pl_state_sts stays ACTIVE. On lp_stallack=1 -> S_STALL_REL, counter cleared. When counter reaches STALL_TIMEOUT-1 -> S_LINKERROR.
- S_STALL_REL: pl_stallreq=0. On lp_stallack=0 -> target state, pl_state_sts updated. Same timeout rule applies.
- S_L1: exit to S_RETRAIN when lp_state_req==ACTIVE (wake always goes through retrain).
- S_RETRAIN: exit to S_ACTIVE when phy_link_up && lp_state_req==ACTIVE && !phy_retrain_req.
- S_LINKRESET: hold LINKRESET_HOLD cycles, then S_RESET.
- S_LINKERROR: pl_stallreq=0, tx_ready=0. Exit to S_RESET when lp_state_req==RESET && !phy_error.
- phy_error in any state except S_RESET and S_LINKERROR -> S_LINKERROR next cycle. This overrides an in-flight stall handshake and clears pl_stallreq.
- Wake: pl_wake_ack <= lp_wake_req in every state (1-cycle follow); pl_clk_req equals pl_wake_ack.
- Counter saturates and never wraps; it is cleared on every state change.

Decomposition:
- ucie_rdi_pkg: rdi_state_e (4-bit encodings above) and the internal FSM enum.
- Sub-module: ucie_rdi_stall_hs, which owns the stallreq/stallack 4-phase handshake and timeout counter and outputs done/timeout pulses.

Test Plan:
- Reset, then phy_link_up=1 and lp_state_req=ACTIVE -> pl_state_sts=1, link_up=1, tx_ready=1 one cycle later.
- ACTIVE, lp_state_req=L1, stallack returned after 5 cycles and dropped after 2 -> pl_stallreq high 6 cycles, pl_state_sts=4, tx_ready=0 throughout.
- STALL_TIMEOUT=8, lp_stallack never asserted -> link_error=1 and pl_state_sts=A exactly 8 cycles after pl_stallreq rises.
- ACTIVE, phy_retrain_req and lp_state_req=LINKRESET together -> target is LINKRESET; after handshake pl_state_sts=9, then 0 after 16 cycles.
- phy_error mid S_STALL_REQ -> next cycle pl_stallreq=0 and pl_state_sts=A; lp_state_req=RESET with phy_error=0 -> pl_state_sts=0.
- lp_wake_req pulsed for 3 cycles -> pl_wake_ack and pl_clk_req high for 3 cycles, delayed by 1 cycle; assert reset mid-handshake -> all outputs 0 next cycle.
